// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants and source encodings for the CDB arbiter
package cdb_arbiter_pkg;

   localparam int Q_WIDTH_DEF = 4;
   localparam int NO_DEP      = 0;

   typedef enum logic {
      SRC_EX  = 1'b0,
      SRC_SLB = 1'b1
   } cdb_src_e;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-producer result FIFO with flush, feeding the CDB arbiter
module cdb_src_fifo import cdb_arbiter_pkg::*; #(
   parameter int Q_WIDTH = Q_WIDTH_DEF,
   parameter int FIFO_AW = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               flush,
   input  logic               push,
   input  logic [Q_WIDTH-1:0] push_tag,
   input  logic [31:0]        push_value,
   input  logic               pop,
   output logic               empty,
   output logic               full,
   output logic [Q_WIDTH-1:0] head_tag,
   output logic [31:0]        head_value
);

   localparam int DEPTH = 2 ** FIFO_AW;

   logic [Q_WIDTH+31:0] mem [DEPTH];
   logic [FIFO_AW-1:0]  head_ptr;
   logic [FIFO_AW-1:0]  tail_ptr;
   logic [FIFO_AW:0]    count;

   assign empty = (count == '0);
   assign full  = (count == (FIFO_AW+1)'(DEPTH));
   assign {head_tag, head_value} = mem[head_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else if (en) begin
         if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
         end else begin
            if (push) tail_ptr <= tail_ptr + FIFO_AW'(1);
            if (pop)  head_ptr <= head_ptr + FIFO_AW'(1);
            case ({push, pop})
               2'b10:   count <= count + (FIFO_AW+1)'(1);
               2'b01:   count <= count - (FIFO_AW+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Entry storage needs no reset; occupancy decides what is meaningful.
   always_ff @(posedge clk) begin
      if (en && !flush && push) mem[tail_ptr] <= {push_tag, push_value};
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter merging execute and SLB results onto one registered CDB
module cdb_arbiter import cdb_arbiter_pkg::*; #(
   parameter int Q_WIDTH = Q_WIDTH_DEF,
   parameter int FIFO_AW = 1
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               rdy_in,
   input  logic               control_hazard,
   input  logic               ex_valid,
   input  logic [Q_WIDTH-1:0] ex_rob_tag,
   input  logic [31:0]        ex_value,
   output logic               ex_ready,
   input  logic               slb_valid,
   input  logic [Q_WIDTH-1:0] slb_rob_tag,
   input  logic [31:0]        slb_value,
   output logic               slb_ready,
   output logic               cdb_valid,
   output logic [Q_WIDTH-1:0] cdb_rob_tag,
   output logic [31:0]        cdb_value,
   output logic               cdb_src
);

   logic               ex_empty, ex_full, slb_empty, slb_full;
   logic [Q_WIDTH-1:0] ex_head_tag, slb_head_tag;
   logic [31:0]        ex_head_value, slb_head_value;
   logic               ex_push, slb_push, ex_pop, slb_pop;
   logic               grant_valid;
   cdb_src_e           grant_src;
   cdb_src_e           last_grant;

   // Ready is a function of registered occupancy only, so no valid-to-ready path exists.
   assign ex_ready  = rst_n_in & rdy_in & ~control_hazard & ~ex_full;
   assign slb_ready = rst_n_in & rdy_in & ~control_hazard & ~slb_full;

   // Tag 0 completes the handshake but is never stored, so it can never be broadcast.
   assign ex_push  = ex_valid  & ex_ready  & (ex_rob_tag  != Q_WIDTH'(NO_DEP));
   assign slb_push = slb_valid & slb_ready & (slb_rob_tag != Q_WIDTH'(NO_DEP));

   assign ex_pop  = grant_valid & (grant_src == SRC_EX)  & ~control_hazard;
   assign slb_pop = grant_valid & (grant_src == SRC_SLB) & ~control_hazard;

   cdb_src_fifo #(.Q_WIDTH(Q_WIDTH), .FIFO_AW(FIFO_AW)) u_ex_fifo (
      .clk        (clk_in),
      .rst_n      (rst_n_in),
      .en         (rdy_in),
      .flush      (control_hazard),
      .push       (ex_push),
      .push_tag   (ex_rob_tag),
      .push_value (ex_value),
      .pop        (ex_pop),
      .empty      (ex_empty),
      .full       (ex_full),
      .head_tag   (ex_head_tag),
      .head_value (ex_head_value)
   );

   cdb_src_fifo #(.Q_WIDTH(Q_WIDTH), .FIFO_AW(FIFO_AW)) u_slb_fifo (
      .clk        (clk_in),
      .rst_n      (rst_n_in),
      .en         (rdy_in),
      .flush      (control_hazard),
      .push       (slb_push),
      .push_tag   (slb_rob_tag),
      .push_value (slb_value),
      .pop        (slb_pop),
      .empty      (slb_empty),
      .full       (slb_full),
      .head_tag   (slb_head_tag),
      .head_value (slb_head_value)
   );

   // Round-robin grant on registered FIFO state: on contention the source not granted last wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_src   = SRC_EX;
      if (!ex_empty && !slb_empty) begin
         grant_valid = 1'b1;
         grant_src   = (last_grant == SRC_EX) ? SRC_SLB : SRC_EX;
      end else if (!ex_empty) begin
         grant_valid = 1'b1;
         grant_src   = SRC_EX;
      end else if (!slb_empty) begin
         grant_valid = 1'b1;
         grant_src   = SRC_SLB;
      end
   end

   // Broadcast register: load the granted head, drop valid on flush or idle, freeze when not ready.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cdb_valid   <= 1'b0;
         cdb_rob_tag <= '0;
         cdb_value   <= '0;
         cdb_src     <= SRC_EX;
         last_grant  <= SRC_SLB;
      end else if (rdy_in) begin
         if (control_hazard) begin
            cdb_valid <= 1'b0;
         end else if (grant_valid) begin
            cdb_valid   <= 1'b1;
            cdb_rob_tag <= (grant_src == SRC_SLB) ? slb_head_tag : ex_head_tag;
            cdb_value   <= (grant_src == SRC_SLB) ? slb_head_value : ex_head_value;
            cdb_src     <= grant_src;
            last_grant  <= grant_src;
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized model-checked bench for cdb_arbiter
module tb_cdb_arbiter;

   localparam int QW = 4;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          rdy_in;
   logic          control_hazard;
   logic          ex_valid;
   logic [QW-1:0] ex_rob_tag;
   logic [31:0]   ex_value;
   logic          ex_ready;
   logic          slb_valid;
   logic [QW-1:0] slb_rob_tag;
   logic [31:0]   slb_value;
   logic          slb_ready;
   logic          cdb_valid;
   logic [QW-1:0] cdb_rob_tag;
   logic [31:0]   cdb_value;
   logic          cdb_src;

   int checks = 0;
   int errors = 0;

   logic [QW+31:0] ex_q[$];
   logic [QW+31:0] slb_q[$];
   logic           m_valid;
   logic [QW-1:0]  m_tag;
   logic [31:0]    m_value;
   logic           m_src;
   logic           m_last;

   cdb_arbiter #(.Q_WIDTH(QW), .FIFO_AW(1)) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .rdy_in         (rdy_in),
      .control_hazard (control_hazard),
      .ex_valid       (ex_valid),
      .ex_rob_tag     (ex_rob_tag),
      .ex_value       (ex_value),
      .ex_ready       (ex_ready),
      .slb_valid      (slb_valid),
      .slb_rob_tag    (slb_rob_tag),
      .slb_value      (slb_value),
      .slb_ready      (slb_ready),
      .cdb_valid      (cdb_valid),
      .cdb_rob_tag    (cdb_rob_tag),
      .cdb_value      (cdb_value),
      .cdb_src        (cdb_src)
   );

   // Free-running clock.
   always #5 clk_in = ~clk_in;

   // Occupancy must never exceed the FIFO depth.
   always @(negedge clk_in) begin
      assert (dut.u_ex_fifo.count <= 2 && dut.u_slb_fifo.count <= 2)
         else $error("FAIL fifo_count ex %0d slb %0d limit 2", dut.u_ex_fifo.count, dut.u_slb_fifo.count);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_ex_ready();
      return rst_n_in && rdy_in && !control_hazard && ex_q.size() < 2;
   endfunction

   function automatic logic model_slb_ready();
      return rst_n_in && rdy_in && !control_hazard && slb_q.size() < 2;
   endfunction

   task automatic model_reset();
      ex_q.delete();
      slb_q.delete();
      m_valid = 1'b0;
      m_tag   = '0;
      m_value = '0;
      m_src   = 1'b0;
      m_last  = 1'b1;
   endtask

   task automatic check_outputs();
      check("ex_ready",    64'(ex_ready),    64'(model_ex_ready()));
      check("slb_ready",   64'(slb_ready),   64'(model_slb_ready()));
      check("cdb_valid",   64'(cdb_valid),   64'(m_valid));
      check("cdb_rob_tag", 64'(cdb_rob_tag), 64'(m_tag));
      check("cdb_value",   64'(cdb_value),   64'(m_value));
      check("cdb_src",     64'(cdb_src),     64'(m_src));
   endtask

   // Advance the reference model across one rising edge using the inputs now applied.
   task automatic model_edge();
      logic ex_acc, slb_acc, have_grant, pick_slb;
      logic [QW+31:0] ent;
      if (!rst_n_in || !rdy_in) return;
      if (control_hazard) begin
         ex_q.delete();
         slb_q.delete();
         m_valid = 1'b0;
         return;
      end
      ex_acc  = ex_valid  && model_ex_ready();
      slb_acc = slb_valid && model_slb_ready();
      have_grant = (ex_q.size() > 0) || (slb_q.size() > 0);
      if (ex_q.size() > 0 && slb_q.size() > 0) pick_slb = ~m_last;
      else pick_slb = (slb_q.size() > 0);
      if (have_grant) begin
         ent = pick_slb ? slb_q.pop_front() : ex_q.pop_front();
         m_valid = 1'b1;
         m_tag   = ent[QW+31:32];
         m_value = ent[31:0];
         m_src   = pick_slb;
         m_last  = pick_slb;
      end else begin
         m_valid = 1'b0;
      end
      if (ex_acc && ex_rob_tag != 0)   ex_q.push_back({ex_rob_tag, ex_value});
      if (slb_acc && slb_rob_tag != 0) slb_q.push_back({slb_rob_tag, slb_value});
   endtask

   task automatic step(input logic ev, input logic [QW-1:0] et, input logic [31:0] evl,
                       input logic sv, input logic [QW-1:0] st, input logic [31:0] svl,
                       input logic rdy, input logic hz);
      ex_valid = ev;   ex_rob_tag = et;  ex_value = evl;
      slb_valid = sv;  slb_rob_tag = st; slb_value = svl;
      rdy_in = rdy;    control_hazard = hz;
      #1;
      check_outputs();
      model_edge();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic reset_mid();
      #2 rst_n_in = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   initial begin
      rst_n_in = 1'b0;
      rdy_in = 1'b1;
      control_hazard = 1'b0;
      ex_valid = 1'b0;  ex_rob_tag = '0;  ex_value = '0;
      slb_valid = 1'b0; slb_rob_tag = '0; slb_value = '0;
      model_reset();
      @(negedge clk_in);
      #1;
      check_outputs();
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // single execute result
      step(1, 3, 32'h1234, 0, 0, 0, 1, 0);
      idle(4);

      // simultaneous first results
      step(1, 5, 32'hA, 1, 6, 32'hB, 1, 0);
      idle(4);

      // saturation
      for (int i = 0; i < 10; i++)
         step(1, QW'(i + 1), 32'h100 + i, 1, QW'((i % 5) + 11), 32'h200 + i, 1, 0);
      idle(6);

      // fill then flush
      for (int i = 0; i < 4; i++)
         step(1, QW'(i + 1), 32'h300 + i, 1, QW'(i + 8), 32'h400 + i, 1, 0);
      step(1, 7, 32'hDEAD, 1, 9, 32'hBEEF, 1, 1);
      idle(4);

      // tag 0 discarded, then rdy_in stall with a pending SLB entry
      step(1, 0, 32'h55, 0, 0, 0, 1, 0);
      idle(3);
      step(0, 0, 0, 1, 9, 32'h999, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 2, 32'h77, 1, 4, 32'h88, 0, 0);
      idle(4);

      // asynchronous reset with entries queued
      step(1, 1, 32'hA1, 1, 2, 32'hB1, 1, 0);
      step(1, 3, 32'hA2, 1, 4, 32'hB2, 1, 0);
      reset_mid();
      idle(5);

      // randomized traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 9) < 6, QW'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 9) < 6, QW'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 4);
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
